seq_shift_unit: RTL and testbench
=================================

Name: seq_shift_unit

Overview:
- Multi-cycle shifter/rotator for the MCU datapath. Generalises the single-bit-per-cycle sequential shifter.
- Adds parametrised width and bits-per-cycle step, plus rotate modes.
- Adds an explicit busy/done/error handshake so the controller can issue back-to-back operations without re-resetting the unit.

Parameters:
- OP_SZ, 32, operand/result width in bits; must be ≥ 2 and a power of 2.
- STEP, 4, maximum bits shifted per clock; power of 2, 1 ≤ STEP ≤ OP_SZ.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- en  input  1  request; sampled only in IDLE.
- op  input  4  operation code: 8 = SLL, 9 = SRL, 10 = SRA, 11 = ROL, 12 = ROR; all others are illegal.
- data  input  OP_SZ  operand.
- shift_value  input  $clog2(OP_SZ)  shift/rotate amount, 0..OP_SZ-1.
- out  output  OP_SZ  result register.
- op_done  output  1  one-cycle completion pulse.
- busy  output  1  high while an accepted operation is in progress.
- op_err  output  1  one-cycle pulse, coincident with op_done, for an illegal op.

Behaviour:
- Reset: sampled on a clk edge with reset=0.
  - out=0, op_done=0, busy=0, op_err=0, state=IDLE, internal acc/rem/op registers cleared.
  - Overrides everything, including an operation in progress, which is discarded with no done pulse.
- States: IDLE, SHIFT.
- IDLE with en=1 at edge N (accept):
  - acc<=data, rem<=shift_value, opr<=op; busy<=1; state<=SHIFT.
  - Inputs are don't-care after edge N.
- SHIFT edge, rem>0:
  - k = min(STEP, rem); acc <= acc op'd by k; rem <= rem-k.
- SHIFT edge, rem=0 (finish):
  - out<=acc, op_done<=1, busy<=0, state<=IDLE.
- Latency: op_done is high during the cycle after edge N+1+ceil(shift_value/STEP).
  - shift_value=0: op_done after edge N+1, out=data.
- Operation semantics per step:
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with acc[OP_SZ-1]; a negative result stays negative.
  - ROL/ROR: bits wrap around; rotate by k is modulo OP_SZ.
- Illegal op:
  - Accepted normally; no shifting (rem forced to 0 at accept).
  - Finish after edge N+1 with out<=data, op_done=1 and op_err=1.
- op_done and op_err: high for exactly one cycle, then return to 0.
- out: holds its value until the next finish or reset.
- en handling:
  - en is ignored while busy.
  - en held high continuously issues a new request on the edge after op_done: the unit is back in IDLE that cycle, so the next accept occurs at the following edge.
  - Minimum spacing is ceil(sh/STEP)+2 cycles per operation.
- en=1 in the same cycle as reset=0: reset wins, nothing accepted.
- All arithmetic is unsigned on rem; no wrap of rem below 0, since k ≤ rem by construction.

Test Plan (OP_SZ=32, STEP=4):
1. Reset, then en=1, op=8, data=0x005061B2, shift_value=9 accepted at edge N -> busy=1, op_done pulses after edge N+4 with out=0xA0C36400, op_err=0, busy=0.
2. op=9, data=18, shift_value=3 -> op_done after edge N+2, out=2. Then op=10, data=0x805061B2, shift_value=6 -> op_done after edge N+3, out=0xFE014186.
3. op=12, data=0x000000F1, shift_value=4 -> out=0x1000000F. op=11, data=0x80000001, shift_value=31 -> out=0xC0000000, done after edge N+9.
4. shift_value=0, op=8, data=0x12345678 -> op_done after edge N+1, out=0x12345678. op=3 (illegal) -> op_done and op_err both pulse one cycle after edge N+1, out=data.
5. Start op=8, shift_value=31; drive reset=0 two cycles later -> outputs cleared on that edge, no op_done pulse. After releasing reset, a new request completes correctly.
6. en held high with alternating data values -> back-to-back operations each produce exactly one op_done. Toggling data/op/shift_value while busy has no effect on the result.

Source files
------------

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter/rotator: shifts up to STEP bits per clock, with a
// busy/done/error handshake so operations can be issued back to back.
module seq_shift_unit #(
   parameter int unsigned OP_SZ = 32,
   parameter int unsigned STEP  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic [3:0]               op,
   input  logic [OP_SZ-1:0]         data,
   input  logic [$clog2(OP_SZ)-1:0] shift_value,
   output logic [OP_SZ-1:0]         out,
   output logic                     op_done,
   output logic                     busy,
   output logic                     op_err
);

   localparam int unsigned SW     = $clog2(OP_SZ);
   localparam logic [SW:0] STEP_C = (SW+1)'(STEP);
   localparam logic [SW:0] SZ_C   = (SW+1)'(OP_SZ);

   localparam logic [3:0] OP_SLL = 4'd8;
   localparam logic [3:0] OP_SRL = 4'd9;
   localparam logic [3:0] OP_SRA = 4'd10;
   localparam logic [3:0] OP_ROL = 4'd11;
   localparam logic [3:0] OP_ROR = 4'd12;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [OP_SZ-1:0] acc;
   logic [OP_SZ-1:0] acc_nxt;
   logic [SW-1:0]    rem;
   logic [3:0]       opr;
   logic             err_q;
   logic             legal;
   logic [SW:0]      k;
   logic [SW:0]      k_c;

   always_comb begin
      legal   = op inside {OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR};
      k       = ({1'b0, rem} < STEP_C) ? {1'b0, rem} : STEP_C;
      // k is nonzero whenever acc_nxt is used, so the complementary
      // rotate shift stays below OP_SZ
      k_c     = SZ_C - k;
      acc_nxt = acc;
      case (opr)
         OP_SLL:  acc_nxt = acc << k;
         OP_SRL:  acc_nxt = acc >> k;
         OP_SRA:  acc_nxt = $signed(acc) >>> k;
         OP_ROL:  acc_nxt = (acc << k) | (acc >> k_c);
         OP_ROR:  acc_nxt = (acc >> k) | (acc << k_c);
         default: acc_nxt = acc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         acc     <= '0;
         rem     <= '0;
         opr     <= '0;
         err_q   <= 1'b0;
         out     <= '0;
         op_done <= 1'b0;
         busy    <= 1'b0;
         op_err  <= 1'b0;
      end else begin
         op_done <= 1'b0;
         op_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  acc   <= data;
                  rem   <= legal ? shift_value : '0;
                  opr   <= op;
                  err_q <= ~legal;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (rem != '0) begin
                  acc <= acc_nxt;
                  rem <= rem - k[SW-1:0];
               end else begin
                  out     <= acc;
                  op_done <= 1'b1;
                  op_err  <= err_q;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench for seq_shift_unit: stimulus pushes expected result and
// completion cycle; a monitor pops and compares on every op_done.
module tb_seq_shift_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [3:0]  op;
   logic [31:0] data;
   logic [4:0]  shift_value;
   logic [31:0] out;
   logic        op_done;
   logic        busy;
   logic        op_err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] exp_out;
      logic        exp_err;
      int          exp_cyc;
   } exp_t;

   exp_t sb[$];

   seq_shift_unit #(.OP_SZ(32), .STEP(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .op         (op),
      .data       (data),
      .shift_value(shift_value),
      .out        (out),
      .op_done    (op_done),
      .busy       (busy),
      .op_err     (op_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (op_err && !op_done) check("err_without_done", 32'(op_err), 32'd0);
         if (op_done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'(op_done), 32'd0);
            end else begin
               e = sb.pop_front();
               check("out", out, e.exp_out);
               check("op_err", 32'(op_err), 32'(e.exp_err));
               check("done_cycle", 32'(cyc), 32'(e.exp_cyc));
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input logic [3:0] o, input logic [31:0] d, input logic [4:0] s,
                        input logic [31:0] exp_out, input logic exp_err, input int lat,
                        input bit push, input bit hold);
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("idle_timeout", 32'(busy), 32'd0);
      en = 1'b1; op = o; data = d; shift_value = s;
      if (push) sb.push_back('{exp_out, exp_err, cyc + 2 + lat});
      @(negedge clk);
      check("busy_after_accept", 32'(busy), 32'd1);
      if (!hold) en = 1'b0;
      data = ~d;
      op = (o == 4'd8) ? 4'd9 : 4'd8;
      shift_value = ~s;
   endtask

   initial begin
      int n;
      reset = 1'b0; en = 1'b1; op = 4'd8; data = 32'hDEADBEEF; shift_value = 5'd3;
      repeat (3) @(negedge clk);
      check("rst_out", out, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(op_done), 32'd0);
      check("rst_err", 32'(op_err), 32'd0);
      en = 1'b0;
      reset = 1'b1;
      @(negedge clk);

      issue(4'd8,  32'h005061B2, 5'd9,  32'hA0C36400, 1'b0, 3, 1'b1, 1'b0);
      issue(4'd9,  32'd18,       5'd3,  32'd2,        1'b0, 1, 1'b1, 1'b0);
      issue(4'd10, 32'h805061B2, 5'd6,  32'hFE014186, 1'b0, 2, 1'b1, 1'b0);
      issue(4'd12, 32'h000000F1, 5'd4,  32'h1000000F, 1'b0, 1, 1'b1, 1'b0);
      issue(4'd11, 32'h80000001, 5'd31, 32'hC0000000, 1'b0, 8, 1'b1, 1'b0);
      issue(4'd8,  32'h12345678, 5'd0,  32'h12345678, 1'b0, 0, 1'b1, 1'b0);
      issue(4'd3,  32'hCAFEF00D, 5'd7,  32'hCAFEF00D, 1'b1, 0, 1'b1, 1'b0);

      // abort a long shift with reset; en high during reset must not be accepted
      issue(4'd8, 32'h0000FFFF, 5'd31, 32'd0, 1'b0, 0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0; en = 1'b1; op = 4'd8; data = 32'h1;
      @(negedge clk);
      check("abort_out", out, 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(op_done), 32'd0);
      @(negedge clk);
      en = 1'b0; reset = 1'b1;
      repeat (12) @(negedge clk);
      check("post_reset_busy", 32'(busy), 32'd0);
      issue(4'd8, 32'h0000FFFF, 5'd16, 32'hFFFF0000, 1'b0, 4, 1'b1, 1'b0);

      // back-to-back with en held high; inputs scrambled while busy
      issue(4'd8,  32'h00000001, 5'd4,  32'h00000010, 1'b0, 1, 1'b1, 1'b1);
      issue(4'd9,  32'hF0000000, 5'd8,  32'h00F00000, 1'b0, 2, 1'b1, 1'b1);
      issue(4'd11, 32'h12345678, 5'd4,  32'h23456781, 1'b0, 1, 1'b1, 1'b1);
      issue(4'd10, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 8, 1'b1, 1'b1);
      issue(4'd13, 32'h0BADF00D, 5'd5,  32'h0BADF00D, 1'b1, 0, 1'b1, 1'b1);
      issue(4'd12, 32'h12345678, 5'd0,  32'h12345678, 1'b0, 0, 1'b1, 1'b0);

      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
